// File: rtl/spi_master_if.sv
// Handshake bundle between a frame requester and spi_master.
// The master modport is the requester; the slave modport is the SPI engine.
interface spi_master_if;
    logic       start;
    logic [9:0] tx_word;
    logic       abort;
    logic       ready;
    logic       done;
    logic       rd_valid;
    logic [7:0] rd_data;

    modport master (
        output start, tx_word, abort,
        input  ready, done, rd_valid, rd_data
    );

    modport slave (
        input  start, tx_word, abort,
        output ready, done, rd_valid, rd_data
    );
endinterface

// File: rtl/spi_master.sv
// SPI frame master: a command bit, then a 10-bit op/payload word shifted MSB first,
// and for op 11 a wait gap plus an 8-bit MISO capture. All outputs come straight from flops.
module spi_master #(
    parameter int RD_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.slave  bus,
    input  logic         MISO,
    output logic         SS_n,
    output logic         MOSI
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CMD   = 3'd2,
        SHIFT = 3'd3,
        WAIT  = 3'd4,
        READ  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  word_q, word_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        rd_valid_q, rd_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            word_q     <= 10'd0;
            sh_q       <= 8'h00;
            rd_data_q  <= 8'h00;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            sh_q       <= sh_d;
            rd_data_q  <= rd_data_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        sh_d      = sh_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = START;
                    word_d  = bus.tx_word;
                end
            end
            START: state_d = CMD;
            CMD:   state_d = SHIFT;
            SHIFT: begin
                if (cnt_q == 4'd9) begin
                    if (word_q[9:8] == 2'b11) state_d = (RD_WAIT == 0) ? READ : WAIT;
                    else                      state_d = DONE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'(RD_WAIT - 1)) state_d = READ;
            end
            READ: begin
                sh_d = {sh_q[6:0], MISO};
                if (cnt_q == 4'd7) begin
                    state_d   = DONE;
                    rd_data_d = {sh_q[6:0], MISO};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides every transition, including the capture into rd_data.
        if (bus.abort && state_q != IDLE) begin
            state_d   = IDLE;
            rd_data_d = rd_data_q;
        end
        cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    end

    // Outputs are decoded from the next state so the flops line up with the state they describe.
    always_comb begin
        ss_n_d     = 1'b0;
        mosi_d     = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        case (state_d)
            IDLE: begin
                ss_n_d  = 1'b1;
                ready_d = 1'b1;
            end
            CMD:   mosi_d = word_q[9];
            SHIFT: mosi_d = word_q[4'd9 - cnt_d];
            DONE: begin
                ss_n_d     = 1'b1;
                done_d     = 1'b1;
                rd_valid_d = (word_q[9:8] == 2'b11);
            end
            START, WAIT, READ: ss_n_d = 1'b0;
            default: begin
                ss_n_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    assign SS_n         = ss_n_q;
    assign MOSI         = mosi_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule
